pipe_ex: RTL
============

// Module: pipe_EX
// PURPOSE
//  Execute stage directly downstream of the decode stage. Latches decode outputs into an ID/EX register
//  and computes the ALU result. Single-cycle ops finish in 1 cycle; MUL runs on an iterative shift-add FSM.
//  While MUL is busy, EXstall freezes PC/IF/ID and bubbles are presented to MEM.
// PARAMETERS
//  MUL_BITS_PER_CYCLE  1   multiplier bits retired per step (1,2,4); N = 32/MUL_BITS_PER_CYCLE steps
// PORTS
//  clk         in   1   clock, rising edge
//  clrn        in   1   reset, synchronous, active-low
//  IDwreg      in   1   register write enable from decode
//  IDm2reg     in   1   writeback from memory
//  IDwmem      in   1   memory write enable
//  IDaluc      in   4   ALU op code
//  IDshift     in   1   A operand = IDimmeOrSa (shift amount)
//  IDaluimm    in   1   B operand = IDimmeOrSa
//  IDwn        in   5   destination register
//  IDqa        in   32  rs1 data
//  IDqb        in   32  rs2 data / store data
//  IDimmeOrSa  in   32  extended immediate or zero-extended shift amount
//  EXstall     out  1   1 = upstream must hold; ID/EX register holds
//  EXwreg      out  1   gated write enable to MEM
//  EXm2reg     out  1   registered m2reg
//  EXwmem      out  1   gated memory write to MEM
//  EXwn        out  5   registered destination
//  EXalu       out  32  ALU/MUL result
//  EXqb        out  32  registered store data
// BEHAVIOUR
//  ID/EX register: clrn=0 at edge -> all fields 0 (NOP). Else load when EXstall=0; hold when EXstall=1.
//  Operands: a = shift ? r_imm : r_qa; b = aluimm ? r_imm : r_qb.
//  aluc: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt (signed), 7 sltu, 8 sll b<<a[4:0],
//   9 srl, A sra, B lui b<<16, C mul (low 32 bits of a*b), D-F reserved -> EXalu=0, controls pass.
//   add/sub wrap modulo 2^32; bits of a above [4:0] ignored for shifts.
//  FSM: IDLE, BUSY, DONE; clrn=0 -> IDLE, counter 0, accumulator 0.
//   IDLE & r_aluc!=C: combinational result, EXstall=0; stay IDLE.
//   IDLE & r_aluc==C: capture a,b, acc=0, cnt=N; EXstall=1 -> BUSY.
//   BUSY: each cycle retire MUL_BITS_PER_CYCLE multiplier LSBs, cnt--; EXstall=1; cnt reaches 0 -> DONE.
//   DONE: EXalu=acc, EXstall=0, outputs valid one cycle; ID/EX loads next instr -> IDLE.
//   MUL occupies ID/EX for N+2 cycles; EXstall high for N+1 of them. No early exit on zero operands.
//  EXstall is combinational: (IDLE & r_aluc==C) | BUSY. While EXstall=1, EXwreg=EXwmem=0 (bubble).
//  Back-to-back MULs: the second starts in the IDLE cycle after DONE; no lost cycle beyond N+2.
//  Reset mid-MUL: next edge -> IDLE, NOP in ID/EX, EXstall=0, partial product discarded.
//  Reset values: all outputs 0.
// CONFIGURATION
//  EX_OVERFLOW_EN defined: adds output EXovf (1 bit). Signed overflow on add/sub
//   (operand signs equal, result sign differs; sub uses ~b+1) -> EXovf=1 and EXwreg forced 0 that cycle.
//   EXovf is 0 after reset and for all other ops.
//  Undefined: no EXovf port; add/sub always wrap and write.
// TESTING
//  add qa=5,qb=3 -> EXalu=8, EXwreg=1, EXstall=0, 1-cycle latency.
//  sra: IDshift=1, imm=4, qb=0x80000000 -> EXalu=0xF8000000; sltu qa=1,qb=0xFFFFFFFF -> 1.
//  mul qa=7,qb=6, N=32 -> EXstall high 33 cycles, EXwreg=0 throughout, then EXalu=42 with EXwreg=1.
//  mul 0xFFFFFFFF*0xFFFFFFFF then immediate 2nd mul 3*4 -> results 1 then 12, no lost cycle.
//  clrn=0 on BUSY cycle 10 -> next cycle EXstall=0, all outputs 0, IDLE.
//  EX_OVERFLOW_EN: add 0x7FFFFFFF+1 -> EXalu=0x80000000, EXovf=1, EXwreg=0.

Source files
------------

// File: rtl/pipe_ex.sv
// rtl/pipe_ex.sv - EX stage: ID/EX register, ALU and iterative shift-add multiplier.
// Optional EX_OVERFLOW_EN adds EXovf and suppresses the register write on signed add/sub overflow.
module pipe_ex #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        IDwreg,
  input  logic        IDm2reg,
  input  logic        IDwmem,
  input  logic [3:0]  IDaluc,
  input  logic        IDshift,
  input  logic        IDaluimm,
  input  logic [4:0]  IDwn,
  input  logic [31:0] IDqa,
  input  logic [31:0] IDqb,
  input  logic [31:0] IDimmeOrSa,
  output logic        EXstall,
  output logic        EXwreg,
  output logic        EXm2reg,
  output logic        EXwmem,
  output logic [4:0]  EXwn,
  output logic [31:0] EXalu,
  output logic [31:0] EXqb
`ifdef EX_OVERFLOW_EN
  ,
  output logic        EXovf
`endif
);

  localparam int N = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [3:0] OP_MUL = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state, w_next;

  logic        r_wreg, r_m2reg, r_wmem, r_shift, r_aluimm;
  logic [3:0]  r_aluc;
  logic [4:0]  r_wn;
  logic [31:0] r_qa, r_qb, r_imm;

  logic [31:0] r_acc, r_mcand, r_mplier;
  logic [5:0]  r_cnt;

  logic [31:0] w_a, w_b, w_alu, w_step, w_sum, w_diff, w_nb;
  logic        w_ovf;

  assign w_a = r_shift  ? r_imm : r_qa;
  assign w_b = r_aluimm ? r_imm : r_qb;

  // ID/EX register freezes while the multiplier owns the stage
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_wmem   <= 1'b0;
      r_aluc   <= 4'h0;
      r_shift  <= 1'b0;
      r_aluimm <= 1'b0;
      r_wn     <= 5'd0;
      r_qa     <= 32'd0;
      r_qb     <= 32'd0;
      r_imm    <= 32'd0;
    end else if (!EXstall) begin
      r_wreg   <= IDwreg;
      r_m2reg  <= IDm2reg;
      r_wmem   <= IDwmem;
      r_aluc   <= IDaluc;
      r_shift  <= IDshift;
      r_aluimm <= IDaluimm;
      r_wn     <= IDwn;
      r_qa     <= IDqa;
      r_qb     <= IDqb;
      r_imm    <= IDimmeOrSa;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_aluc == OP_MUL) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 6'd1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_step = r_acc;
    for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) w_step = w_step + (r_mcand << i);
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 6'd0;
    end else if (r_state == S_IDLE && r_aluc == OP_MUL) begin
      r_acc    <= 32'd0;
      r_mcand  <= w_a;
      r_mplier <= w_b;
      r_cnt    <= 6'(N);
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_step;
      r_mcand  <= r_mcand << MUL_BITS_PER_CYCLE;
      r_mplier <= r_mplier >> MUL_BITS_PER_CYCLE;
      r_cnt    <= r_cnt - 6'd1;
    end
  end

  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  assign w_nb   = ~w_b + 32'd1;

  always_comb begin
    w_alu = 32'd0;
    case (r_aluc)
      4'h0: w_alu = w_sum;
      4'h1: w_alu = w_diff;
      4'h2: w_alu = w_a & w_b;
      4'h3: w_alu = w_a | w_b;
      4'h4: w_alu = w_a ^ w_b;
      4'h5: w_alu = ~(w_a | w_b);
      4'h6: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      4'h7: w_alu = {31'd0, w_a < w_b};
      4'h8: w_alu = w_b << w_a[4:0];
      4'h9: w_alu = w_b >> w_a[4:0];
      4'hA: w_alu = $signed(w_b) >>> w_a[4:0];
      4'hB: w_alu = {w_b[15:0], 16'd0};
      default: w_alu = 32'd0;
    endcase
  end

`ifdef EX_OVERFLOW_EN
  // subtraction overflow is judged on a + (~b+1)
  always_comb begin
    w_ovf = 1'b0;
    if (r_aluc == 4'h0)
      w_ovf = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
    else if (r_aluc == 4'h1)
      w_ovf = (w_a[31] == w_nb[31]) && (w_diff[31] != w_a[31]);
  end
  assign EXovf = w_ovf;
`else
  assign w_ovf = 1'b0;
`endif

  assign EXstall = ((r_state == S_IDLE) && (r_aluc == OP_MUL)) || (r_state == S_BUSY);
  assign EXwreg  = r_wreg & ~EXstall & ~w_ovf;
  assign EXwmem  = r_wmem & ~EXstall;
  assign EXm2reg = r_m2reg;
  assign EXwn    = r_wn;
  assign EXqb    = r_qb;
  assign EXalu   = (r_state == S_DONE) ? r_acc :
                   (r_aluc == OP_MUL)  ? 32'd0 : w_alu;

  logic w_unused;
  assign w_unused = ^w_nb;

endmodule
